mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
Load/store sequencer in front of the 512-byte, byte-wide data memory. It accepts one RISC-V load or store request at a time (byte, halfword or word) and issues the byte accesses in order, one per cycle, in little-endian order. For loads it assembles the bytes and sign- or zero-extends the result, then returns a single response. It sits between the core's load/store path and the data memory's chip-select, enable, address and data pins.

Parameters:
MEM_DEPTH, 512, number of addressable bytes; an access whose last byte is at or above MEM_DEPTH is a fault.
ADDR_WIDTH, 32, width of request and memory byte addresses.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE; a request is accepted on a posedge with req_valid && req_ready.
req_write  input  1  1 = store, 0 = load.
req_funct3  input  3  RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_address  input  ADDR_WIDTH  byte address.
req_write_data  input  32  store data; low 1/2/4 bytes are used.
resp_valid  output  1  one-cycle response pulse.
resp_read_data  output  32  extended load result; 0 for stores and errors.
resp_error  output  1  valid with resp_valid: misaligned, illegal funct3 or out of range.
busy  output  1  high in ACCESS and RESP.
mem_chip_select_d  output  1  memory chip select.
mem_address  output  ADDR_WIDTH  memory byte address.
mem_write_data  output  8  memory write byte.
mem_write_enable  output  1  memory write strobe.
mem_read_enable  output  1  memory read strobe.
mem_read_data  input  8  memory read byte (combinational from the memory).

Behaviour:
- State machine states: IDLE, ACCESS, RESP. A 2-bit byte counter idx and the latched request fields are held in registers.
- Reset (synchronous, active-high) forces:
  - state = IDLE, idx = 0, latched fields = 0;
  - resp_valid = 0, resp_read_data = 0, resp_error = 0, busy = 0;
  - all mem_* outputs = 0.
- Reset during ACCESS aborts the request with no response. Bytes already written stay written. This block never drives the memory's reset.
- IDLE:
  - req_ready = 1.
  - On accept, latch write, funct3, address and write_data, and compute N = 1/2/4 from funct3[1:0].
  - An error is flagged when any of the following holds:
    - funct3 is 011, 110 or 111;
    - funct3 is 100 or 101 with req_write = 1;
    - H with addr[0] != 0;
    - W with addr[1:0] != 0;
    - address + N - 1 >= MEM_DEPTH (compute with ADDR_WIDTH+1 bits so there is no wrap-around).
  - Error → go directly to RESP; no memory strobe is ever asserted.
  - No error → go to ACCESS with idx = 0.
- ACCESS, cycle for byte idx (one cycle per byte):
  - mem_chip_select_d = 1, mem_address = base + idx.
  - Store: mem_write_enable = 1, mem_write_data = write_data[8*idx+7 : 8*idx], mem_read_enable = 0. The memory commits the byte at the posedge ending the cycle.
  - Load: mem_read_enable = 1, mem_write_enable = 0. Capture mem_read_data into assembly byte idx at the posedge ending the cycle.
  - When idx == N-1, go to RESP. Otherwise idx increments.
- RESP (exactly one cycle):
  - resp_valid = 1, busy = 1, all mem_* = 0.
  - Load result: B/H sign-extend bit 7/15, BU/HU zero-extend, W passes through.
  - Then go to IDLE. resp_* returns to 0 outside RESP.
- Latency: request accepted at edge E0 → ACCESS cycles between edges E0..E0+N → resp_valid high in the cycle after edge E0+N. That is N+1 cycles of busy. Errors respond in the cycle after E0.
- Back-to-back: req_ready is 0 in ACCESS/RESP. The next request can be accepted in the first IDLE cycle after RESP, so there is a minimum of one idle cycle between requests.
- Outside ACCESS all mem_* outputs are 0. mem_write_enable and mem_read_enable are never high together.
- req_valid held high while not ready has no effect, and request inputs are ignored until accept.

Test Plan:
1. SW addr 0x10, data 0xDEADBEEF, then LW 0x10 → writes bytes EF, BE, AD, DE at 0x10..0x13 on 4 consecutive cycles; the load returns resp_read_data = 0xDEADBEEF, resp_error = 0, with resp_valid 5 cycles after accept.
2. SB 0x20 = 0x80, then LB 0x20 → 0xFFFFFF80; LBU 0x20 → 0x00000080. Each has a single memory strobe and resp_valid 2 cycles after accept.
3. SH 0x30 = 0x8001, then LH 0x30 → 0xFFFF8001; LHU → 0x00008001.
4. Error cases each give resp_error = 1 and resp_read_data = 0 in the cycle after accept, with no mem_chip_select_d pulse:
   - LW 0x11 (misaligned);
   - SH 0x31 (misaligned);
   - LW 0x1FE (bytes 0x1FE..0x201 exceed MEM_DEPTH 512);
   - funct3 = 011;
   - store with funct3 = 100.
5. SW 0x40 = 0x11223344 with reset asserted on the third ACCESS cycle → no resp_valid, state = IDLE and all mem_* = 0 on the next cycle. A following LW 0x40 shows bytes 0x44 and 0x33 updated and the upper two bytes still at their old value.
6. req_valid held high continuously with alternating LW/SW → each accepted only when req_ready = 1, one response per request, never two strobes in one cycle, and mem_address never outside base..base+N-1.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer: turns one RISC-V B/H/W load or store into in-order
// byte accesses on a byte-wide memory, then returns a single response.
module mem_access_sequencer #(
  parameter int MEM_DEPTH  = 512,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_write_data,
  output logic                  resp_valid,
  output logic [31:0]           resp_read_data,
  output logic                  resp_error,
  output logic                  busy,
  output logic                  mem_chip_select_d,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_write_data,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic [7:0]            mem_read_data
);

  // Handshake: a request is taken on a posedge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is a one-cycle pulse
  // with resp_read_data/resp_error valid alongside it.
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);

  state_t                state;
  logic [1:0]            idx;
  logic [1:0]            last_idx;
  logic                  lat_write;
  logic [2:0]            lat_funct3;
  logic [ADDR_WIDTH-1:0] lat_address;
  logic [31:0]           lat_wdata;
  logic [31:0]           assembly;

  logic [1:0]            req_last;
  logic [ADDR_WIDTH:0]   req_end;
  logic                  req_err;
  logic [31:0]           load_word;
  logic [31:0]           load_ext;
  logic [1:0]            idx_next;

  assign req_ready = (state == IDLE);
  assign idx_next  = idx + 2'd1;

  function automatic logic [7:0] store_byte(input logic [31:0] d, input logic [1:0] i);
    case (i)
      2'd0:    store_byte = d[7:0];
      2'd1:    store_byte = d[15:8];
      2'd2:    store_byte = d[23:16];
      default: store_byte = d[31:24];
    endcase
  endfunction

  // Request decode; the end address is one bit wider so it cannot wrap.
  always_comb begin
    req_last = 2'd0;
    case (req_funct3[1:0])
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
    req_end = {1'b0, req_address} + {{(ADDR_WIDTH-1){1'b0}}, req_last};
    req_err = 1'b0;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_address[0];
      3'b010:  req_err = (req_address[1:0] != 2'b00);
      3'b100:  req_err = req_write;
      3'b101:  req_err = req_write | req_address[0];
      default: req_err = 1'b1;
    endcase
    if (req_end >= DEPTH_LIMIT) req_err = 1'b1;
  end

  // The byte arriving this cycle is merged in so the final byte of a load
  // reaches the response without an extra cycle.
  always_comb begin
    load_word = assembly;
    case (idx)
      2'd0:    load_word[7:0]   = mem_read_data;
      2'd1:    load_word[15:8]  = mem_read_data;
      2'd2:    load_word[23:16] = mem_read_data;
      default: load_word[31:24] = mem_read_data;
    endcase
    case (lat_funct3)
      3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
      3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
      3'b100:  load_ext = {24'd0, load_word[7:0]};
      3'b101:  load_ext = {16'd0, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      idx               <= 2'd0;
      last_idx          <= 2'd0;
      lat_write         <= 1'b0;
      lat_funct3        <= 3'd0;
      lat_address       <= '0;
      lat_wdata         <= 32'd0;
      assembly          <= 32'd0;
      resp_valid        <= 1'b0;
      resp_read_data    <= 32'd0;
      resp_error        <= 1'b0;
      busy              <= 1'b0;
      mem_chip_select_d <= 1'b0;
      mem_address       <= '0;
      mem_write_data    <= 8'd0;
      mem_write_enable  <= 1'b0;
      mem_read_enable   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid     <= 1'b0;
          resp_error     <= 1'b0;
          resp_read_data <= 32'd0;
          if (req_valid) begin
            lat_write   <= req_write;
            lat_funct3  <= req_funct3;
            lat_address <= req_address;
            lat_wdata   <= req_write_data;
            last_idx    <= req_last;
            idx         <= 2'd0;
            assembly    <= 32'd0;
            busy        <= 1'b1;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else begin
              state             <= ACCESS;
              mem_chip_select_d <= 1'b1;
              mem_address       <= req_address;
              mem_write_enable  <= req_write;
              mem_read_enable   <= ~req_write;
              mem_write_data    <= req_write ? req_write_data[7:0] : 8'd0;
            end
          end
        end
        ACCESS: begin
          if (!lat_write) assembly <= load_word;
          if (idx == last_idx) begin
            state             <= RESP;
            mem_chip_select_d <= 1'b0;
            mem_address       <= '0;
            mem_write_data    <= 8'd0;
            mem_write_enable  <= 1'b0;
            mem_read_enable   <= 1'b0;
            resp_valid        <= 1'b1;
            resp_read_data    <= lat_write ? 32'd0 : load_ext;
          end else begin
            idx            <= idx_next;
            mem_address    <= lat_address + {{(ADDR_WIDTH-2){1'b0}}, idx_next};
            mem_write_data <= lat_write ? store_byte(lat_wdata, idx_next) : 8'd0;
          end
        end
        RESP: begin
          state          <= IDLE;
          busy           <= 1'b0;
          resp_valid     <= 1'b0;
          resp_error     <= 1'b0;
          resp_read_data <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a 512-byte behavioural memory.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_write_data;
  logic        resp_valid, resp_error, busy;
  logic [31:0] resp_read_data;
  logic        mem_chip_select_d, mem_write_enable, mem_read_enable;
  logic [31:0] mem_address;
  logic [7:0]  mem_write_data, mem_read_data;

  int total = 0;
  int bad   = 0;

  // results of the last run_req
  logic [31:0] r_rdata;
  logic        r_err, r_long;
  int          r_lat, r_strobes, r_both, r_oob;
  logic [7:0]  r_wbyte [4];
  logic [31:0] r_waddr [4];

  mem_access_sequencer #(.MEM_DEPTH(512), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_write_data(req_write_data),
    .resp_valid(resp_valid), .resp_read_data(resp_read_data), .resp_error(resp_error),
    .busy(busy), .mem_chip_select_d(mem_chip_select_d), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory ignores writes while the system is held in reset.
  logic [7:0] mem [0:511];
  assign mem_read_data = (mem_address < 32'd512) ? mem[mem_address[8:0]] : 8'h00;
  always @(posedge clk)
    if (!reset && mem_chip_select_d && mem_write_enable && mem_address < 32'd512)
      mem[mem_address[8:0]] <= mem_write_data;

  function automatic int bytes_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    int  n;
    bit  got;
    int  w;
    n = bytes_of(f3);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_address = addr; req_write_data = wd;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_address = 32'd0; req_write_data = 32'd0;
    got = 0; r_lat = 0; r_strobes = 0; r_both = 0; r_oob = 0; r_err = 1'b0; r_rdata = 32'd0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_write_enable && mem_read_enable) r_both++;
      if (mem_chip_select_d) begin
        if (r_strobes < 4) begin
          r_wbyte[r_strobes] = mem_write_data;
          r_waddr[r_strobes] = mem_address;
        end
        if (mem_address < addr || mem_address > addr + n - 1) r_oob++;
        r_strobes++;
      end
      if (resp_valid) begin
        got = 1; r_lat = k; r_rdata = resp_read_data; r_err = resp_error;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL resp_timeout addr=%h got=none exp=resp_valid", addr);
    end
    @(negedge clk);
    r_long = resp_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_address = 32'd0; req_write_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({resp_valid, resp_error, busy, mem_chip_select_d, mem_write_enable, mem_read_enable} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000",
        {resp_valid, resp_error, busy, mem_chip_select_d, mem_write_enable, mem_read_enable});
    end
    total++;
    if (resp_read_data !== 32'd0 || mem_address !== 32'd0 || mem_write_data !== 8'd0) begin
      bad++; $display("FAIL reset_buses got=%h/%h/%h exp=0/0/0", resp_read_data, mem_address, mem_write_data);
    end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    reset = 1'b0;
  endtask

  task automatic test_word();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    total++;
    if (r_strobes !== 4) begin bad++; $display("FAIL sw_strobes got=%0d exp=4", r_strobes); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (r_wbyte[i] !== exp_b[i] || r_waddr[i] !== 32'h10 + i) begin
        bad++; $display("FAIL sw_byte%0d got=%h@%h exp=%h@%h", i, r_wbyte[i], r_waddr[i], exp_b[i], 32'h10 + i);
      end
    end
    total++;
    if (r_lat !== 5 || r_err !== 1'b0 || r_rdata !== 32'd0) begin
      bad++; $display("FAIL sw_resp got=lat%0d err%b %h exp=lat5 err0 0", r_lat, r_err, r_rdata);
    end
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    total++;
    if (r_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", r_rdata); end
    total++;
    if (r_lat !== 5 || r_err !== 1'b0 || r_strobes !== 4) begin
      bad++; $display("FAIL lw_timing got=lat%0d err%b str%0d exp=lat5 err0 str4", r_lat, r_err, r_strobes);
    end
    total++;
    if (r_long !== 1'b0 || r_both !== 0 || r_oob !== 0) begin
      bad++; $display("FAIL lw_pulse got=long%b both%0d oob%0d exp=0/0/0", r_long, r_both, r_oob);
    end
  endtask

  task automatic test_byte_half();
    run_req(1'b1, 3'b000, 32'h20, 32'h12345680);
    total++;
    if (r_strobes !== 1 || r_wbyte[0] !== 8'h80 || r_lat !== 2) begin
      bad++; $display("FAIL sb got=str%0d %h lat%0d exp=str1 80 lat2", r_strobes, r_wbyte[0], r_lat);
    end
    run_req(1'b0, 3'b000, 32'h20, 32'h0);
    total++;
    if (r_rdata !== 32'hFFFFFF80 || r_lat !== 2 || r_strobes !== 1) begin
      bad++; $display("FAIL lb got=%h lat%0d str%0d exp=ffffff80 lat2 str1", r_rdata, r_lat, r_strobes);
    end
    run_req(1'b0, 3'b100, 32'h20, 32'h0);
    total++;
    if (r_rdata !== 32'h00000080 || r_lat !== 2) begin
      bad++; $display("FAIL lbu got=%h lat%0d exp=00000080 lat2", r_rdata, r_lat);
    end
    run_req(1'b1, 3'b001, 32'h30, 32'hFFFF8001);
    total++;
    if (r_strobes !== 2 || r_wbyte[0] !== 8'h01 || r_wbyte[1] !== 8'h80 || r_lat !== 3) begin
      bad++; $display("FAIL sh got=str%0d %h %h lat%0d exp=str2 01 80 lat3", r_strobes, r_wbyte[0], r_wbyte[1], r_lat);
    end
    run_req(1'b0, 3'b001, 32'h30, 32'h0);
    total++;
    if (r_rdata !== 32'hFFFF8001 || r_lat !== 3) begin
      bad++; $display("FAIL lh got=%h lat%0d exp=ffff8001 lat3", r_rdata, r_lat);
    end
    run_req(1'b0, 3'b101, 32'h30, 32'h0);
    total++;
    if (r_rdata !== 32'h00008001) begin bad++; $display("FAIL lhu got=%h exp=00008001", r_rdata); end
  endtask

  task automatic test_errors();
    logic        e_wr [6];
    logic [2:0]  e_f3 [6];
    logic [31:0] e_ad [6];
    e_wr[0] = 0; e_f3[0] = 3'b010; e_ad[0] = 32'h11;
    e_wr[1] = 1; e_f3[1] = 3'b001; e_ad[1] = 32'h31;
    e_wr[2] = 0; e_f3[2] = 3'b010; e_ad[2] = 32'h1FE;
    e_wr[3] = 0; e_f3[3] = 3'b011; e_ad[3] = 32'h0;
    e_wr[4] = 1; e_f3[4] = 3'b100; e_ad[4] = 32'h0;
    e_wr[5] = 0; e_f3[5] = 3'b000; e_ad[5] = 32'h200;
    for (int i = 0; i < 6; i++) begin
      run_req(e_wr[i], e_f3[i], e_ad[i], 32'hFFFFFFFF);
      total++;
      if (r_err !== 1'b1 || r_rdata !== 32'd0 || r_lat !== 1 || r_strobes !== 0) begin
        bad++; $display("FAIL err_case%0d got=err%b %h lat%0d str%0d exp=err1 0 lat1 str0",
                        i, r_err, r_rdata, r_lat, r_strobes);
      end
    end
    // last legal word and byte of the memory
    run_req(1'b0, 3'b010, 32'h1FC, 32'h0);
    total++;
    if (r_err !== 1'b0 || r_lat !== 5) begin
      bad++; $display("FAIL edge_lw got=err%b lat%0d exp=err0 lat5", r_err, r_lat);
    end
    run_req(1'b1, 3'b000, 32'h1FF, 32'h0000005A);
    run_req(1'b0, 3'b100, 32'h1FF, 32'h0);
    total++;
    if (r_err !== 1'b0 || r_rdata !== 32'h5A) begin
      bad++; $display("FAIL edge_lbu got=err%b %h exp=err0 0000005a", r_err, r_rdata);
    end
  endtask

  task automatic test_reset_abort();
    int w;
    int late;
    run_req(1'b1, 3'b010, 32'h40, 32'hAABBCCDD);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_address = 32'h40; req_write_data = 32'h11223344;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_chip_select_d !== 1'b1 || mem_address !== 32'h42) begin
      bad++; $display("FAIL abort_third got=cs%b %h exp=cs1 00000042", mem_chip_select_d, mem_address);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({resp_valid, busy, mem_chip_select_d, mem_write_enable, mem_read_enable} !== 5'b0 ||
        mem_address !== 32'd0 || mem_write_data !== 8'd0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL abort_idle got=rv%b bz%b cs%b we%b re%b %h %h rdy%b exp=all0 rdy1",
        resp_valid, busy, mem_chip_select_d, mem_write_enable, mem_read_enable, mem_address, mem_write_data, req_ready);
    end
    late = 0;
    repeat (5) begin @(negedge clk); if (resp_valid) late++; end
    total++;
    if (late !== 0) begin bad++; $display("FAIL abort_noresp got=%0d exp=0", late); end
    run_req(1'b0, 3'b010, 32'h40, 32'h0);
    total++;
    if (r_rdata !== 32'hAABB3344) begin bad++; $display("FAIL abort_mem got=%h exp=aabb3344", r_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    logic        t_wr [4];
    logic [31:0] t_ad [4];
    logic [31:0] t_wd [4];
    logic [31:0] t_ex [4];
    logic [31:0] exp_v;
    logic [31:0] cur_base;
    int next, resp_cnt, strobes, both, oob, errs;
    bit done;
    t_wr[0] = 1; t_ad[0] = 32'h50; t_wd[0] = 32'hCAFEF00D; t_ex[0] = 32'h0;
    t_wr[1] = 0; t_ad[1] = 32'h50; t_wd[1] = 32'h0;        t_ex[1] = 32'hCAFEF00D;
    t_wr[2] = 1; t_ad[2] = 32'h54; t_wd[2] = 32'h0BADBEEF; t_ex[2] = 32'h0;
    t_wr[3] = 0; t_ad[3] = 32'h54; t_wd[3] = 32'h0;        t_ex[3] = 32'h0BADBEEF;
    next = 0; resp_cnt = 0; strobes = 0; both = 0; oob = 0; errs = 0; done = 0; cur_base = 32'h50;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (mem_write_enable && mem_read_enable) both++;
      if (mem_chip_select_d) begin
        strobes++;
        if (mem_address < cur_base || mem_address > cur_base + 3) oob++;
      end
      if (resp_valid) begin
        resp_cnt++;
        if (resp_error) errs++;
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          total++;
          if (resp_read_data !== exp_v) begin
            bad++; $display("FAIL b2b_data%0d got=%h exp=%h", resp_cnt, resp_read_data, exp_v);
          end
        end
      end
      if (req_ready) begin
        if (next < 4) begin
          req_valid = 1'b1; req_write = t_wr[next]; req_funct3 = 3'b010;
          req_address = t_ad[next]; req_write_data = t_wd[next];
          exp_q.push_back(t_ex[next]);
          cur_base = t_ad[next];
          next++;
        end else begin
          req_valid = 1'b0; done = 1;
        end
      end else begin
        // junk that would error if it were wrongly accepted
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011;
        req_address = 32'h1FF; req_write_data = $urandom;
      end
    end
    req_valid = 1'b0;
    total++;
    if (!done || resp_cnt !== 4 || errs !== 0) begin
      bad++; $display("FAIL b2b_count got=done%b resp%0d err%0d exp=done1 resp4 err0", done, resp_cnt, errs);
    end
    total++;
    if (strobes !== 16 || both !== 0 || oob !== 0) begin
      bad++; $display("FAIL b2b_strobes got=str%0d both%0d oob%0d exp=16/0/0", strobes, both, oob);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
